// File: rtl/csr_trap_unit_pkg.sv
// rtl/csr_trap_unit_pkg.sv - CSR addresses, encodings, masks and architectural state struct
// Purpose: shared definitions for csr_trap_unit and its arbitration sub-module.
package csr_trap_unit_pkg;

  // Implemented CSR addresses
  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MTVAL    = 12'h343;
  localparam logic [11:0] CSR_MIP      = 12'h344;
  localparam logic [11:0] CSR_SATP     = 12'h180;
  localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
  localparam logic [11:0] CSR_MHARTID  = 12'hF14;

  // Interrupt cause codes and their mip/mie bit positions
  localparam logic [3:0] IRQ_CODE_MSI = 4'd3;
  localparam logic [3:0] IRQ_CODE_MTI = 4'd7;
  localparam logic [3:0] IRQ_CODE_MEI = 4'd11;
  localparam int MIP_MSIP = 3;
  localparam int MIP_MTIP = 7;
  localparam int MIP_MEIP = 11;

  // mstatus field positions
  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;

  localparam logic [63:0] MSTATUS_WMASK = 64'h0000_0000_0000_1888;
  localparam logic [63:0] MIE_WMASK     = 64'h0000_0000_0000_0888;

  // Zicsr funct3[1:0]; bit 2 only selects the immediate source form
  typedef enum logic [1:0] {
    CSR_OP_NONE = 2'b00,
    CSR_OP_RW   = 2'b01,
    CSR_OP_RS   = 2'b10,
    CSR_OP_RC   = 2'b11
  } csr_op_e;

  typedef enum logic [1:0] {
    MODE_U = 2'b00,
    MODE_S = 2'b01,
    MODE_M = 2'b11
  } mode_e;

  typedef struct packed {
    logic [1:0]  mode;
    logic [63:0] mstatus;
    logic [63:0] mie;
    logic [63:0] mip;
    logic [63:0] mtvec;
    logic [63:0] mscratch;
    logic [63:0] mepc;
    logic [63:0] mcause;
    logic [63:0] mtval;
    logic [63:0] mcycle;
    logic [63:0] mhartid;
  } csr_regs_t;

  // Keep only mie/mpie/mpp; unsupported privilege levels in mpp collapse to U
  function automatic logic [63:0] mstatus_legalize(input logic [63:0] v);
    logic [63:0] r;
    r = v & MSTATUS_WMASK;
    if (r[MSTATUS_MPP_LO +: 2] != MODE_M) r[MSTATUS_MPP_LO +: 2] = MODE_U;
    return r;
  endfunction

endpackage

// File: rtl/csr_trap_unit_if.sv
// rtl/csr_trap_unit_if.sv - commit-side CSR/trap bus between the pipeline and csr_trap_unit
// Ports (master = pipeline, slave = csr_trap_unit):
//   commit/csr/exc/mret/irq request signals in, csr_rdata/csr_illegal/redirect out.
interface csr_trap_unit_if;
  logic        commit_valid;
  logic [63:0] commit_pc;
  logic        csr_valid;
  logic [2:0]  csr_op;
  logic [11:0] csr_addr;
  logic [63:0] csr_src;
  logic        csr_src_zero;
  logic        exc_valid;
  logic [3:0]  exc_cause;
  logic [63:0] exc_tval;
  logic        mret_valid;
  logic        irq_msip;
  logic        irq_mtip;
  logic        irq_meip;
  logic [63:0] csr_rdata;
  logic        csr_illegal;
  logic        redirect_valid;
  logic [63:0] redirect_pc;

  modport master (
    output commit_valid, commit_pc, csr_valid, csr_op, csr_addr, csr_src, csr_src_zero,
           exc_valid, exc_cause, exc_tval, mret_valid, irq_msip, irq_mtip, irq_meip,
    input  csr_rdata, csr_illegal, redirect_valid, redirect_pc
  );

  modport slave (
    input  commit_valid, commit_pc, csr_valid, csr_op, csr_addr, csr_src, csr_src_zero,
           exc_valid, exc_cause, exc_tval, mret_valid, irq_msip, irq_mtip, irq_meip,
    output csr_rdata, csr_illegal, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/csr_trap_unit_arb.sv
// rtl/csr_trap_unit_arb.sv - combinational exception/interrupt/mret arbitration and vector computation
// Ports: commit_valid_i, exc_*_i, mret_valid_i, mip_i, mie_i, mstatus_mie_i, mode_i, mtvec_i in;
//        take_trap_o, take_mret_o, trap_irq_o, trap_cause_o, trap_vec_o out.
module csr_trap_arb
  import csr_trap_unit_pkg::*;
(
  input  logic        commit_valid_i,
  input  logic        exc_valid_i,
  input  logic [3:0]  exc_cause_i,
  input  logic        mret_valid_i,
  input  logic [63:0] mip_i,
  input  logic [63:0] mie_i,
  input  logic        mstatus_mie_i,
  input  logic [1:0]  mode_i,
  input  logic [63:0] mtvec_i,
  output logic        take_trap_o,
  output logic        take_mret_o,
  output logic        trap_irq_o,
  output logic [63:0] trap_cause_o,
  output logic [63:0] trap_vec_o
);
  logic [63:0] active;
  logic        irq_pending;
  logic [3:0]  irq_code;
  logic [3:0]  code;
  logic [63:0] base;

  always_comb begin
    active      = mip_i & mie_i;
    // Below M-mode interrupts are taken regardless of mstatus.mie
    irq_pending = (active != 64'd0) && (mstatus_mie_i || (mode_i != MODE_M));

    if (active[MIP_MEIP])      irq_code = IRQ_CODE_MEI;
    else if (active[MIP_MSIP]) irq_code = IRQ_CODE_MSI;
    else                       irq_code = IRQ_CODE_MTI;

    trap_irq_o  = commit_valid_i && !exc_valid_i && irq_pending;
    take_trap_o = (commit_valid_i && exc_valid_i) || trap_irq_o;
    take_mret_o = commit_valid_i && !take_trap_o && mret_valid_i;

    code         = trap_irq_o ? irq_code : exc_cause_i;
    trap_cause_o = {trap_irq_o, 59'd0, code};

    // Vectored mode only offsets interrupts; exceptions always use the base
    base = {mtvec_i[63:2], 2'b00};
    if (trap_irq_o && (mtvec_i[1:0] == 2'b01)) trap_vec_o = base + {58'd0, code, 2'b00};
    else                                        trap_vec_o = base;
  end
endmodule

// File: rtl/csr_trap_unit.sv
// rtl/csr_trap_unit.sv - commit-side machine CSR file, Zicsr execution and trap/mret redirect
// Ports: clk, reset (async active-low); bus (slave modport of csr_trap_unit_if);
//        regs_o full architectural CSR state; mode_o current privilege mode.
module csr_trap_unit
  import csr_trap_unit_pkg::*;
#(
  parameter logic [63:0] HART_ID   = 64'h0,
  parameter logic [63:0] MTVEC_RST = 64'h0
)
(
  input  logic             clk,
  input  logic             reset,
  csr_trap_unit_if.slave   bus,
  output csr_regs_t        regs_o,
  output logic [1:0]       mode_o
);
  csr_regs_t   regs_q, regs_d;
  logic        redirect_valid_q, redirect_valid_d;
  logic [63:0] redirect_pc_q, redirect_pc_d;
  logic [63:0] rdata, wdata;
  logic        illegal, do_write;
  csr_op_e     op;
  logic        take_trap, take_mret, trap_irq;
  logic [63:0] trap_cause, trap_vec;

  csr_trap_arb u_arb (
    .commit_valid_i (bus.commit_valid),
    .exc_valid_i    (bus.exc_valid),
    .exc_cause_i    (bus.exc_cause),
    .mret_valid_i   (bus.mret_valid),
    .mip_i          (regs_q.mip),
    .mie_i          (regs_q.mie),
    .mstatus_mie_i  (regs_q.mstatus[MSTATUS_MIE]),
    .mode_i         (regs_q.mode),
    .mtvec_i        (regs_q.mtvec),
    .take_trap_o    (take_trap),
    .take_mret_o    (take_mret),
    .trap_irq_o     (trap_irq),
    .trap_cause_o   (trap_cause),
    .trap_vec_o     (trap_vec)
  );

  always_comb begin
    rdata   = 64'd0;
    illegal = 1'b0;
    case (bus.csr_addr)
      CSR_MSTATUS:  rdata = regs_q.mstatus;
      CSR_MIE:      rdata = regs_q.mie;
      CSR_MTVEC:    rdata = regs_q.mtvec;
      CSR_MSCRATCH: rdata = regs_q.mscratch;
      CSR_MEPC:     rdata = regs_q.mepc;
      CSR_MCAUSE:   rdata = regs_q.mcause;
      CSR_MTVAL:    rdata = regs_q.mtval;
      CSR_MIP:      rdata = regs_q.mip;
      CSR_SATP:     rdata = 64'd0;
      CSR_MCYCLE:   rdata = regs_q.mcycle;
      CSR_MHARTID:  rdata = regs_q.mhartid;
      default:      illegal = 1'b1;
    endcase
  end

  assign bus.csr_rdata   = rdata;
  assign bus.csr_illegal = illegal;

  assign op = csr_op_e'(bus.csr_op[1:0]);

  always_comb begin
    case (op)
      CSR_OP_RW: wdata = bus.csr_src;
      CSR_OP_RS: wdata = rdata | bus.csr_src;
      CSR_OP_RC: wdata = rdata & ~bus.csr_src;
      default:   wdata = rdata;
    endcase
  end

  // RS/RC with a zero source are pure reads
  assign do_write = bus.commit_valid && bus.csr_valid && !illegal && !take_trap && !take_mret &&
                    (op != CSR_OP_NONE) && ((op == CSR_OP_RW) || !bus.csr_src_zero);

  always_comb begin
    regs_d           = regs_q;
    regs_d.mcycle    = regs_q.mcycle + 64'd1;
    regs_d.mip       = {52'd0, bus.irq_meip, 3'd0, bus.irq_mtip, 3'd0, bus.irq_msip, 3'd0};
    redirect_valid_d = 1'b0;
    redirect_pc_d    = redirect_pc_q;

    if (take_trap) begin
      regs_d.mepc                          = bus.commit_pc;
      regs_d.mcause                        = trap_cause;
      regs_d.mtval                         = trap_irq ? 64'd0 : bus.exc_tval;
      regs_d.mstatus[MSTATUS_MPIE]         = regs_q.mstatus[MSTATUS_MIE];
      regs_d.mstatus[MSTATUS_MIE]          = 1'b0;
      regs_d.mstatus[MSTATUS_MPP_LO +: 2]  = regs_q.mode;
      regs_d.mode                          = MODE_M;
      redirect_valid_d                     = 1'b1;
      redirect_pc_d                        = trap_vec;
    end else if (take_mret) begin
      regs_d.mstatus[MSTATUS_MIE]          = regs_q.mstatus[MSTATUS_MPIE];
      regs_d.mstatus[MSTATUS_MPIE]         = 1'b1;
      regs_d.mode                          = regs_q.mstatus[MSTATUS_MPP_LO +: 2];
      regs_d.mstatus[MSTATUS_MPP_LO +: 2]  = MODE_U;
      redirect_valid_d                     = 1'b1;
      redirect_pc_d                        = regs_q.mepc;
    end else if (do_write) begin
      // mip, satp and mhartid silently drop writes
      case (bus.csr_addr)
        CSR_MSTATUS:  regs_d.mstatus  = mstatus_legalize(wdata);
        CSR_MIE:      regs_d.mie      = wdata & MIE_WMASK;
        CSR_MTVEC:    regs_d.mtvec    = wdata;
        CSR_MSCRATCH: regs_d.mscratch = wdata;
        CSR_MEPC:     regs_d.mepc     = {wdata[63:2], 2'b00};
        CSR_MCAUSE:   regs_d.mcause   = wdata;
        CSR_MTVAL:    regs_d.mtval    = wdata;
        CSR_MCYCLE:   regs_d.mcycle   = wdata;
        default:      ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      regs_q           <= '{mode: MODE_M, mtvec: MTVEC_RST, mhartid: HART_ID, default: '0};
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= 64'd0;
    end else begin
      regs_q           <= regs_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
    end
  end

  assign bus.redirect_valid = redirect_valid_q;
  assign bus.redirect_pc    = redirect_pc_q;
  assign regs_o             = regs_q;
  assign mode_o             = regs_q.mode;
endmodule

// File: tb/tb_csr_trap_unit.sv
// tb/tb_csr_trap_unit.sv - directed and randomized self-checking bench for csr_trap_unit
module tb_csr_trap_unit;
  import csr_trap_unit_pkg::*;

  localparam logic [63:0] HART   = 64'h3;
  localparam logic [63:0] MTVEC0 = 64'h8000_0100;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  csr_trap_unit_if bus();
  csr_regs_t  regs;
  logic [1:0] mode;

  csr_trap_unit #(.HART_ID(HART), .MTVEC_RST(MTVEC0)) dut (
    .clk    (clk),
    .reset  (reset),
    .bus    (bus),
    .regs_o (regs),
    .mode_o (mode)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: architectural fields kept as plain scalars
  logic        s_mie, s_mpie;
  logic [1:0]  s_mpp, m_mode;
  logic [63:0] m_mie, m_mip, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval, m_mcycle;
  logic        exp_rv;
  logic [63:0] exp_pc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] m_mstatus();
    return (64'(s_mpp) << 11) | (64'(s_mpie) << 7) | (64'(s_mie) << 3);
  endfunction

  function automatic csr_regs_t m_state();
    csr_regs_t e;
    e.mode = m_mode;     e.mstatus = m_mstatus(); e.mie = m_mie;     e.mip = m_mip;
    e.mtvec = m_mtvec;   e.mscratch = m_mscratch; e.mepc = m_mepc;   e.mcause = m_mcause;
    e.mtval = m_mtval;   e.mcycle = m_mcycle;     e.mhartid = HART;
    return e;
  endfunction

  task automatic chk_regs(input string tag);
    csr_regs_t e;
    e = m_state();
    n_cmp++;
    assert (regs === e) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, regs, e);
    end
  endtask

  // {illegal, value}
  function automatic logic [64:0] m_read(input logic [11:0] a);
    case (a)
      CSR_MSTATUS:  return {1'b0, m_mstatus()};
      CSR_MIE:      return {1'b0, m_mie};
      CSR_MTVEC:    return {1'b0, m_mtvec};
      CSR_MSCRATCH: return {1'b0, m_mscratch};
      CSR_MEPC:     return {1'b0, m_mepc};
      CSR_MCAUSE:   return {1'b0, m_mcause};
      CSR_MTVAL:    return {1'b0, m_mtval};
      CSR_MIP:      return {1'b0, m_mip};
      CSR_SATP:     return {1'b0, 64'd0};
      CSR_MCYCLE:   return {1'b0, m_mcycle};
      CSR_MHARTID:  return {1'b0, HART};
      default:      return {1'b1, 64'd0};
    endcase
  endfunction

  task automatic model_reset();
    s_mie = 0; s_mpie = 0; s_mpp = 2'b00; m_mode = 2'b11;
    m_mie = 0; m_mip = 0; m_mtvec = MTVEC0; m_mscratch = 0; m_mepc = 0;
    m_mcause = 0; m_mtval = 0; m_mcycle = 0; exp_rv = 0; exp_pc = 0;
  endtask

  task automatic m_trap(input bit intr, input logic [3:0] code, input logic [63:0] tval,
                        input logic [63:0] pc);
    logic [63:0] base;
    m_mepc   = pc;
    m_mcause = intr ? ((64'd1 << 63) + 64'(code)) : 64'(code);
    m_mtval  = intr ? 64'd0 : tval;
    s_mpie   = s_mie;
    s_mie    = 1'b0;
    s_mpp    = m_mode;
    m_mode   = 2'b11;
    base     = m_mtvec - (m_mtvec % 4);
    exp_rv   = 1'b1;
    exp_pc   = (intr && (m_mtvec % 4 == 1)) ? base + 4 * 64'(code) : base;
  endtask

  task automatic idle();
    bus.commit_valid = 0; bus.commit_pc = 0; bus.csr_valid = 0; bus.csr_op = 0;
    bus.csr_addr = CSR_MSCRATCH; bus.csr_src = 0; bus.csr_src_zero = 0;
    bus.exc_valid = 0; bus.exc_cause = 0; bus.exc_tval = 0; bus.mret_valid = 0;
  endtask

  // One clock: check combinational read at negedge, advance model, check state after posedge
  task automatic step();
    logic [64:0] r;
    logic [63:0] nv, nxt_cyc, act, old;
    logic [1:0]  opl;
    bit          irq_en;
    @(negedge clk);
    r = m_read(bus.csr_addr);
    old = r[63:0];
    chk("csr_illegal", 64'(bus.csr_illegal), 64'(r[64]));
    chk("csr_rdata", bus.csr_rdata, old);
    nxt_cyc = m_mcycle + 64'd1;
    exp_rv  = 1'b0;
    act     = m_mip & m_mie;
    irq_en  = (act != 0) && (s_mie || m_mode != 2'b11);
    opl     = bus.csr_op[1:0];
    if (bus.commit_valid) begin
      if (bus.exc_valid)
        m_trap(1'b0, bus.exc_cause, bus.exc_tval, bus.commit_pc);
      else if (irq_en)
        m_trap(1'b1, act[11] ? 4'd11 : (act[3] ? 4'd3 : 4'd7), 64'd0, bus.commit_pc);
      else if (bus.mret_valid) begin
        exp_rv = 1'b1; exp_pc = m_mepc;
        s_mie = s_mpie; s_mpie = 1'b1; m_mode = s_mpp; s_mpp = 2'b00;
      end else if (bus.csr_valid && !r[64] && opl != 0 && (opl == 1 || !bus.csr_src_zero)) begin
        if (opl == 1)      nv = bus.csr_src;
        else if (opl == 2) nv = old | bus.csr_src;
        else               nv = old & ~bus.csr_src;
        case (bus.csr_addr)
          CSR_MSTATUS: begin
            s_mie = nv[3]; s_mpie = nv[7];
            s_mpp = (nv[12:11] == 2'b11) ? 2'b11 : 2'b00;
          end
          CSR_MIE:      m_mie = nv & ((64'd1 << 3) | (64'd1 << 7) | (64'd1 << 11));
          CSR_MTVEC:    m_mtvec = nv;
          CSR_MSCRATCH: m_mscratch = nv;
          CSR_MEPC:     m_mepc = nv - (nv % 4);
          CSR_MCAUSE:   m_mcause = nv;
          CSR_MTVAL:    m_mtval = nv;
          CSR_MCYCLE:   nxt_cyc = nv;
          default: ;
        endcase
      end
    end
    m_mcycle = nxt_cyc;
    m_mip = (64'(bus.irq_meip) << 11) | (64'(bus.irq_mtip) << 7) | (64'(bus.irq_msip) << 3);
    @(posedge clk);
    #1;
    chk("redirect_valid", 64'(bus.redirect_valid), 64'(exp_rv));
    if (exp_rv) chk("redirect_pc", bus.redirect_pc, exp_pc);
    chk("mode_o", 64'(mode), 64'(m_mode));
    chk_regs("regs_o");
  endtask

  task automatic csr(input logic [2:0] op, input logic [11:0] a, input logic [63:0] s, input bit z);
    idle();
    bus.commit_valid = 1; bus.commit_pc = 64'h8000_0000; bus.csr_valid = 1;
    bus.csr_op = op; bus.csr_addr = a; bus.csr_src = s; bus.csr_src_zero = z;
    step();
  endtask

  task automatic peek(input string tag, input logic [11:0] a, input logic [63:0] e);
    idle();
    bus.csr_addr = a;
    #1;
    chk(tag, bus.csr_rdata, e);
  endtask

  logic [11:0] addr_tbl [14];
  logic [2:0]  op_tbl [8];

  initial begin
    addr_tbl = '{CSR_MSTATUS, CSR_MIE, CSR_MTVEC, CSR_MSCRATCH, CSR_MEPC, CSR_MCAUSE, CSR_MTVAL,
                 CSR_MIP, CSR_SATP, CSR_MCYCLE, CSR_MHARTID, 12'h7C0, 12'h301, 12'hF11};
    op_tbl   = '{3'b001, 3'b010, 3'b011, 3'b101, 3'b110, 3'b111, 3'b000, 3'b100};
    bus.irq_msip = 0; bus.irq_mtip = 0; bus.irq_meip = 0;
    idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_regs("reset_regs");
    chk("reset_redirect_valid", 64'(bus.redirect_valid), 64'd0);
    chk("reset_redirect_pc", bus.redirect_pc, 64'd0);
    chk("reset_mode", 64'(mode), 64'd3);
    reset = 1'b1;

    // Plain write to mscratch
    csr(3'b001, CSR_MSCRATCH, 64'hDEAD, 1'b0);
    peek("mscratch_readback", CSR_MSCRATCH, 64'hDEAD);
    chk("no_redirect_on_csr", 64'(bus.redirect_valid), 64'd0);

    // mstatus masking, and RC with zero source is a read only
    csr(3'b010, CSR_MSTATUS, '1, 1'b0);
    peek("mstatus_set_all", CSR_MSTATUS, 64'h1888);
    csr(3'b111, CSR_MSTATUS, 64'd0, 1'b1);
    peek("mstatus_rc_zero", CSR_MSTATUS, 64'h1888);
    csr(3'b001, CSR_MHARTID, 64'hFF, 1'b0);
    peek("mhartid_ro", CSR_MHARTID, HART);

    // Synchronous exception
    csr(3'b001, CSR_MTVEC, 64'h8000_1000, 1'b0);
    idle();
    bus.commit_valid = 1; bus.commit_pc = 64'h8000_0010; bus.exc_valid = 1;
    bus.exc_cause = 4'd2; bus.exc_tval = 64'h1234;
    step();
    chk("exc_redirect_valid", 64'(bus.redirect_valid), 64'd1);
    chk("exc_redirect_pc", bus.redirect_pc, 64'h8000_1000);
    chk("exc_mepc", regs.mepc, 64'h8000_0010);
    chk("exc_mcause", regs.mcause, 64'd2);
    chk("exc_mstatus", regs.mstatus, 64'h1880);
    idle();
    step();

    // Vectored timer interrupt
    csr(3'b001, CSR_MTVEC, 64'h8000_1001, 1'b0);
    csr(3'b001, CSR_MIE, 64'h80, 1'b0);
    csr(3'b010, CSR_MSTATUS, 64'h8, 1'b0);
    bus.irq_mtip = 1;
    idle();
    step();
    idle();
    bus.commit_valid = 1; bus.commit_pc = 64'h8000_0020;
    step();
    chk("irq_redirect_pc", bus.redirect_pc, 64'h8000_101C);
    chk("irq_mcause", regs.mcause, 64'h8000_0000_0000_0007);
    chk("irq_mtval", regs.mtval, 64'd0);
    bus.irq_mtip = 0;
    idle();
    step();

    // Exception beats pending MEI and a simultaneous mret
    csr(3'b001, CSR_MIE, 64'h888, 1'b0);
    csr(3'b010, CSR_MSTATUS, 64'h8, 1'b0);
    bus.irq_meip = 1;
    idle();
    step();
    idle();
    bus.commit_valid = 1; bus.commit_pc = 64'h8000_0040; bus.exc_valid = 1;
    bus.exc_cause = 4'd5; bus.exc_tval = 64'h55; bus.mret_valid = 1;
    step();
    chk("race_mcause", regs.mcause, 64'd5);
    chk("race_redirect_pc", bus.redirect_pc, 64'h8000_1000);
    bus.irq_meip = 0;
    idle();
    step();
    idle();
    bus.commit_valid = 1; bus.commit_pc = 64'h8000_1000; bus.mret_valid = 1;
    step();
    chk("mret_redirect_pc", bus.redirect_pc, 64'h8000_0040);
    chk("mret_mstatus", regs.mstatus, 64'h88);
    chk("mret_mode", 64'(mode), 64'd3);

    // mcycle wrap
    csr(3'b001, CSR_MCYCLE, '1, 1'b0);
    chk("mcycle_written", regs.mcycle, 64'hFFFF_FFFF_FFFF_FFFF);
    idle();
    step();
    chk("mcycle_wrapped", regs.mcycle, 64'd0);

    // Reset while a redirect is about to be registered
    idle();
    bus.commit_valid = 1; bus.commit_pc = 64'h8000_0080; bus.exc_valid = 1; bus.exc_cause = 4'd1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("async_mcycle_clear", regs.mcycle, 64'd0);
    @(posedge clk);
    #1;
    chk("reset_drops_redirect", 64'(bus.redirect_valid), 64'd0);
    model_reset();
    chk_regs("mid_reset_regs");
    idle();
    reset = 1'b1;

    // Randomized traffic; irq lines only move on idle cycles
    for (int i = 0; i < 500; i++) begin
      idle();
      if ($urandom_range(0, 4) == 0) begin
        bus.irq_msip = ($urandom_range(0, 3) == 0);
        bus.irq_mtip = ($urandom_range(0, 3) == 0);
        bus.irq_meip = ($urandom_range(0, 3) == 0);
      end else begin
        bus.commit_valid = ($urandom_range(0, 7) != 0);
        bus.commit_pc    = {$urandom, $urandom} & ~64'h3;
        bus.csr_valid    = ($urandom_range(0, 3) != 0);
        bus.csr_op       = op_tbl[$urandom_range(0, 7)];
        bus.csr_addr     = addr_tbl[$urandom_range(0, 13)];
        bus.csr_src_zero = ($urandom_range(0, 5) == 0);
        bus.csr_src      = bus.csr_src_zero ? 64'd0 :
                           (($urandom_range(0, 1) == 0) ? {$urandom, $urandom} : 64'($urandom_range(0, 4095)));
        bus.exc_valid    = ($urandom_range(0, 9) == 0);
        bus.exc_cause    = 4'($urandom_range(0, 15));
        bus.exc_tval     = {$urandom, $urandom};
        bus.mret_valid   = ($urandom_range(0, 9) == 0);
      end
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
